// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its surroundings: instruction memory port,
// stall/redirect control, and the registered IF/ID instruction output.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [15:0]       if_instr;
  logic [15:0]       if_imm;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_next_pc;
  logic              if_valid;

  // Handshake: no valid/ready pairing. if_valid qualifies the IF/ID fields in
  // the cycle they are presented; stall freezes the whole stage for one cycle;
  // redirect (priority over stall) restarts fetch at redirect_pc.
  modport master (
    output imem_addr, if_instr, if_imm, if_pc, if_next_pc, if_valid,
    input  imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_instr, if_imm, if_pc, if_next_pc, if_valid,
    output imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one/two-word instruction assembly into a
// registered IF/ID output, with stall and redirect support.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       NOP_WORD = 16'hF800
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic          dbg_state
);

  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [15:0]       op_hold, op_hold_n;
  logic [ADDR_W-1:0] op_pc, op_pc_n;
  logic [15:0]       instr, instr_n;
  logic [15:0]       imm, imm_n;
  logic [ADDR_W-1:0] out_pc, out_pc_n;
  logic [ADDR_W-1:0] out_next, out_next_n;
  logic              valid, valid_n;
  logic              two_word;

  always_comb begin
    case (bus.imem_data[15:11])
      5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101: two_word = 1'b1;
      default:                                          two_word = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OP;
      pc       <= RESET_PC;
      op_hold  <= '0;
      op_pc    <= '0;
      instr    <= NOP_WORD;
      imm      <= '0;
      out_pc   <= '0;
      out_next <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      op_hold  <= op_hold_n;
      op_pc    <= op_pc_n;
      instr    <= instr_n;
      imm      <= imm_n;
      out_pc   <= out_pc_n;
      out_next <= out_next_n;
      valid    <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    op_hold_n  = op_hold;
    op_pc_n    = op_pc;
    instr_n    = instr;
    imm_n      = imm;
    out_pc_n   = out_pc;
    out_next_n = out_next;
    valid_n    = valid;
    if (bus.redirect) begin
      // Any half-fetched two-word instruction is simply forgotten.
      pc_n    = bus.redirect_pc;
      state_n = S_OP;
      valid_n = 1'b0;
      instr_n = NOP_WORD;
      imm_n   = '0;
    end else if (!bus.stall) begin
      pc_n = pc + ADDR_W'(1);
      case (state)
        S_OP: begin
          if (two_word) begin
            op_hold_n = bus.imem_data;
            op_pc_n   = pc;
            state_n   = S_IMM;
            valid_n   = 1'b0;
            instr_n   = NOP_WORD;
            imm_n     = '0;
          end else begin
            instr_n    = bus.imem_data;
            imm_n      = '0;
            out_pc_n   = pc;
            out_next_n = pc + ADDR_W'(1);
            valid_n    = 1'b1;
          end
        end
        S_IMM: begin
          instr_n    = op_hold;
          imm_n      = bus.imem_data;
          out_pc_n   = op_pc;
          out_next_n = pc + ADDR_W'(1);
          valid_n    = 1'b1;
          state_n    = S_OP;
        end
        default: state_n = S_OP;
      endcase
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.if_instr   = instr;
  assign bus.if_imm     = imm;
  assign bus.if_pc      = out_pc;
  assign bus.if_next_pc = out_next;
  assign bus.if_valid   = valid;
  assign dbg_state      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stall,
// redirect and program content against an instruction-level reference model.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hF800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  fetch_unit_if #(.ADDR_W(16)) bus ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  assign bus.imem_data = mem[bus.imem_addr];

  int errors = 0;
  int checks = 0;

  // Reference model: the program counter, whether an opcode word is waiting
  // for its immediate, and what the IF/ID register should hold.
  logic [15:0] m_pc, m_op, m_op_pc;
  bit          m_half;
  logic [15:0] e_instr, e_imm, e_pc, e_next;
  bit          e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit needs_imm(input logic [15:0] w);
    logic [4:0] op;
    op = w[15:11];
    return op inside {5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_half = 0; m_op = 0; m_op_pc = 0;
    e_instr = NOP; e_imm = 0; e_pc = 0; e_next = 0; e_valid = 0;
  endtask

  task automatic model_step();
    logic [15:0] w;
    if (bus.redirect) begin
      m_pc = bus.redirect_pc; m_half = 0;
      e_valid = 0; e_instr = NOP; e_imm = 0;
    end else if (!bus.stall) begin
      w = mem[m_pc];
      if (m_half) begin
        e_instr = m_op; e_imm = w; e_pc = m_op_pc; e_next = m_pc + 16'd1;
        e_valid = 1; m_half = 0;
      end else if (needs_imm(w)) begin
        m_op = w; m_op_pc = m_pc; m_half = 1;
        e_valid = 0; e_instr = NOP; e_imm = 0;
      end else begin
        e_instr = w; e_imm = 0; e_pc = m_pc; e_next = m_pc + 16'd1; e_valid = 1;
      end
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".imem_addr"},  bus.imem_addr,  m_pc);
    chk({ph, ".valid"},      bus.if_valid,   e_valid);
    chk({ph, ".instr"},      bus.if_instr,   e_instr);
    chk({ph, ".imm"},        bus.if_imm,     e_imm);
    chk({ph, ".pc"},         bus.if_pc,      e_pc);
    chk({ph, ".next_pc"},    bus.if_next_pc, e_next);
    chk({ph, ".state"},      dbg_state,      m_half);
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic cycle(input string ph, input logic st, input logic rd, input logic [15:0] rpc);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2800; mem[1] = 16'h2900; mem[2] = 16'hF800; mem[3] = 16'h0800;
    mem[4] = 16'h3A00; mem[5] = 16'h1234; mem[6] = 16'h1000; mem[7] = 16'h1800;
    mem[8] = 16'h7000; mem[9] = 16'hBEEF; mem[10] = 16'h7800; mem[11] = 16'h5555;
    mem[16'h40] = 16'h2000; mem[16'h41] = 16'h2100; mem[16'hFFFF] = 16'hA000;

    model_reset();
    @(negedge clk);
    compare_all("reset");
    @(negedge clk);
    rst = 0;
    compare_all("reset_rel");

    // One-word stream, LDM pair, two filler words.
    for (int i = 0; i < 8; i++) cycle("seq", 0, 0, 0);
    chk("ldm_next_fetch", bus.imem_addr, 16'd8);
    // LDD opcode, then stall three cycles in the immediate phase.
    cycle("ldd_op", 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("ldd_stall", 1, 0, 0);
    cycle("ldd_done", 0, 0, 0);
    chk("ldd_imm", bus.if_imm, 16'hBEEF);
    // STD opcode, then redirect with stall while the immediate is pending.
    cycle("std_op", 0, 0, 0);
    cycle("redir", 1, 1, 16'h0040);
    cycle("redir_t0", 0, 0, 0);
    cycle("redir_t1", 0, 0, 0);
    // SHL straddling the address wrap.
    mem[0] = 16'h0003;
    cycle("wrap_go", 0, 1, 16'hFFFF);
    cycle("wrap_op", 0, 0, 0);
    cycle("wrap_imm", 0, 0, 0);
    chk("wrap_next_pc", bus.if_next_pc, 16'h0001);
    chk("wrap_pc", bus.if_pc, 16'hFFFF);

    // Asynchronous reset in the middle of an immediate fetch.
    cycle("ar_go", 0, 1, 16'h0008);
    cycle("ar_op", 0, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst = 0;
    compare_all("async_rel");
    mem[0] = 16'h2800;
    cycle("restart", 0, 0, 0);

    // Random stall/redirect traffic over random program content.
    for (int i = 0; i < 3000; i++) begin
      logic st, rd;
      logic [15:0] tgt;
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 5);
      tgt = ($urandom_range(0, 9) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                        : 16'($urandom);
      cycle("rand", st, rd, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
